vram_arbiter: RTL
=================

# vram_arbiter

Single-port VRAM arbiter for the VDP. It shares the one synchronous VRAM port (address in cycle t, `vramOut` valid in cycle t+1) between three requesters: the background pattern fetcher, the sprite fetcher and the CPU data port. The background fetcher cannot stall, so it owns the port outright while active. Sprites and the CPU share the remaining cycles under fixed priority with a starvation guard, and CPU writes are buffered so the CPU side never loses a write.

## Interface
- `FIFO_DEPTH`, 4: CPU write-buffer entries; power of two.
- `STARVE_LIMIT`, 8: consecutive denied cycles after which the CPU beats the sprite fetcher.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `bgActive` in 1: background fetcher owns the port this cycle.
- `bgAddr` in 14: background VRAM address, combinational from the fetcher.
- `sprReq` in 1: sprite fetcher requests a read. Held until granted.
- `sprAddr` in 14: sprite read address, stable while `sprReq` is high.
- `sprGnt` out 1: sprite address is on the port this cycle. Combinational.
- `sprDataValid` out 1: `vramOut` holds the sprite data this cycle. Registered.
- `cpuWrValid`, `cpuWrAddr[13:0]`, `cpuWrData[7:0]` in: CPU write push.
- `cpuWrReady` out 1: FIFO count < `FIFO_DEPTH`.
- `cpuRdValid`, `cpuRdAddr[13:0]` in: CPU read request.
- `cpuRdReady` out 1: no read is pending.
- `cpuRdData` out 8: last CPU read result. Registered and held.
- `cpuRdDataValid` out 1: one-cycle pulse when `cpuRdData` updates.
- `vramAddr` out 14, `vramWe` out 1, `vramWrData` out 8: VRAM port drive.
- `vramOut` in 8: VRAM read data from the previous cycle's address.
- `cpuStarved` out 1: debug; the starvation guard fired this cycle.

## Operation
- Each cycle the port has exactly one owner. Owner selection is combinational, in this priority order:
  1. BG, if `bgActive`.
  2. CPU, if CPU work is waiting and `starveCnt >= STARVE_LIMIT`.
  3. SPR, if `sprReq`.
  4. CPU_WR, if the FIFO is non-empty.
  5. CPU_RD, if a read is pending and the FIFO is empty.
  6. NONE.
- "CPU work waiting" means the FIFO is non-empty or a read is pending.
- Inside a CPU grant (from rule 2 or rules 4–5), a FIFO entry always drains before a pending read. This preserves read-after-write order.
- Port drive per owner:
  - BG: `bgAddr`.
  - SPR: `sprAddr`.
  - CPU_WR: FIFO head, with `vramWe`=1.
  - CPU_RD: the pending address.
  - NONE: `vramAddr`=0, `vramWe`=0.
- `vramWe` is 1 only for CPU_WR.
- `dataOwner` register: holds the read owner from the previous cycle; loads NONE for writes.
- `sprDataValid` = (`dataOwner` == SPR).
- When `dataOwner` == CPU_RD: `cpuRdData` <= `vramOut` and `cpuRdDataValid` pulses the following cycle. The pending flag clears on the grant cycle.
- `starveCnt` (4 bits, saturating):
  - Increments when CPU work is waiting and the owner is SPR.
  - Clears on any CPU grant, and whenever no CPU work is waiting.
  - Holds during BG.
- `cpuStarved` is high whenever rule 2 selects the owner.
- FIFO push: `cpuWrValid && cpuWrReady`. Pop: CPU_WR grant.
- When the FIFO is full, a same-cycle push is refused even if a pop occurs, because `cpuWrReady` is computed from count only.
- Read accept: `cpuRdValid && cpuRdReady` latches the address and sets the pending flag.
- A read accepted in the same cycle as a write push waits behind that write.

## Timing
- Grant to data: SPR data arrives one cycle after `sprGnt`. CPU read data is visible two cycles after grant.
- `bgActive` rising in the same cycle as `sprReq` denies the sprite. The sprite stays stalled for as long as BG is active, with no lost request.
- Reset values:
  - FIFO empty, so `cpuWrReady`=1.
  - Read not pending, so `cpuRdReady`=1.
  - `dataOwner`=NONE.
  - `sprDataValid`=0, `cpuRdDataValid`=0, `cpuRdData`=0, `starveCnt`=0, `cpuStarved`=0.
  - `vramWe`=0, `vramAddr`=0, `vramWrData`=0.
- Reset mid-operation: buffered writes and the pending read are discarded, and no data-valid pulse follows.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap. Count is one bit wider.

## Structure
- Shared package `vdp_pkg`:
  - `VRAM_AW`=14.
  - Owner enum `{OwnNone, OwnBg, OwnSpr, OwnCpuWr, OwnCpuRd}`.
  - The `cpu_wr_t` struct (addr, data).
- Sub-module `vram_wr_fifo`: synchronous FIFO with async reset, push/pop/full/empty/count, and head visible combinationally.
- Owner selection is one `always_comb`. `dataOwner`, `starveCnt` and the read-pending register sit in the top module.

## Test plan
- Reset released with idle inputs -> `vramAddr`=0, `vramWe`=0, both ready outputs 1, no valid pulses.
- `bgActive`=1, `bgAddr`=0x3800, `sprReq`=1 for 10 cycles -> `vramAddr`=0x3800 throughout, `sprGnt`=0. When BG drops, `sprGnt`=1 on the next cycle and `sprDataValid`=1 one cycle later.
- CPU writes 0x1234←0xAB then reads 0x1234 in the next cycle, port free -> write grant, then read grant, then `cpuRdData`=0xAB with a one-cycle `cpuRdDataValid`.
- Five back-to-back writes with BG active -> four accepted, `cpuWrReady`=0 on the fifth. All four drain in order once BG drops.
- `sprReq` held continuously with one CPU write queued -> exactly 8 SPR grants, then `cpuStarved`=1 and a CPU_WR grant, after which SPR grants resume.
- `rst` pulsed with 3 FIFO entries queued and a read pending -> no writes reach VRAM, no `cpuRdDataValid`, `cpuWrReady`=1.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared VDP types: VRAM address width, port-owner encoding and the buffered CPU write.
package vdp_pkg;
  localparam int VRAM_AW = 14;

  typedef enum logic [2:0] {OwnNone, OwnBg, OwnSpr, OwnCpuWr, OwnCpuRd} owner_t;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         data;
  } cpu_wr_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and VRAM-port signals of the arbiter; the arbiter takes the slave side.
interface vram_arbiter_if;
  import vdp_pkg::*;

  logic               bgActive;
  logic [VRAM_AW-1:0] bgAddr;
  logic               sprReq;
  logic [VRAM_AW-1:0] sprAddr;
  logic               sprGnt;
  logic               sprDataValid;
  logic               cpuWrValid;
  logic [VRAM_AW-1:0] cpuWrAddr;
  logic [7:0]         cpuWrData;
  logic               cpuWrReady;
  logic               cpuRdValid;
  logic [VRAM_AW-1:0] cpuRdAddr;
  logic               cpuRdReady;
  logic [7:0]         cpuRdData;
  logic               cpuRdDataValid;
  logic [VRAM_AW-1:0] vramAddr;
  logic               vramWe;
  logic [7:0]         vramWrData;
  logic [7:0]         vramOut;
  logic               cpuStarved;

  modport master (
    output bgActive, bgAddr, sprReq, sprAddr, cpuWrValid, cpuWrAddr, cpuWrData,
           cpuRdValid, cpuRdAddr, vramOut,
    input  sprGnt, sprDataValid, cpuWrReady, cpuRdReady, cpuRdData, cpuRdDataValid,
           vramAddr, vramWe, vramWrData, cpuStarved
  );

  modport slave (
    input  bgActive, bgAddr, sprReq, sprAddr, cpuWrValid, cpuWrAddr, cpuWrData,
           cpuRdValid, cpuRdAddr, vramOut,
    output sprGnt, sprDataValid, cpuWrReady, cpuRdReady, cpuRdData, cpuRdDataValid,
           vramAddr, vramWe, vramWrData, cpuStarved
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// CPU write buffer: synchronous FIFO with combinational head; storage is not reset.
module vram_wr_fifo
  import vdp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cpu_wr_t                  wr,
  input  logic                     pop,
  output cpu_wr_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  cpu_wr_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: BG owns the port outright, sprites and CPU share the rest
// under fixed priority with a starvation guard that lets queued CPU work through.
module vram_arbiter
  import vdp_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);
  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);

  owner_t             owner;
  owner_t             data_owner;
  logic               starved;
  logic               cpu_wait;
  logic               rd_pend;
  logic               rd_accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [3:0]         starve_cnt;
  logic [VRAM_AW-1:0] rd_addr;
  cpu_wr_t            fifo_in;
  cpu_wr_t            fifo_head;

  assign fifo_in   = '{addr: bus.cpuWrAddr, data: bus.cpuWrData};
  assign push      = bus.cpuWrValid && bus.cpuWrReady;
  assign pop       = (owner == OwnCpuWr);
  assign rd_accept = bus.cpuRdValid && !rd_pend;
  assign cpu_wait  = (fifo_count != '0) || rd_pend;

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wr    (fifo_in),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.cpuWrReady = !fifo_full;
  assign bus.cpuRdReady = !rd_pend;
  assign bus.cpuStarved = starved;

  // Within any CPU grant the FIFO drains first, keeping read-after-write order.
  always_comb begin
    owner   = OwnNone;
    starved = 1'b0;
    if (bus.bgActive) begin
      owner = OwnBg;
    end else if (cpu_wait && (starve_cnt >= STARVE_TH)) begin
      starved = 1'b1;
      owner   = fifo_empty ? OwnCpuRd : OwnCpuWr;
    end else if (bus.sprReq) begin
      owner = OwnSpr;
    end else if (!fifo_empty) begin
      owner = OwnCpuWr;
    end else if (rd_pend) begin
      owner = OwnCpuRd;
    end
  end

  always_comb begin
    bus.vramAddr   = '0;
    bus.vramWe     = 1'b0;
    bus.vramWrData = '0;
    bus.sprGnt     = 1'b0;
    case (owner)
      OwnBg:    bus.vramAddr = bus.bgAddr;
      OwnSpr: begin
        bus.vramAddr = bus.sprAddr;
        bus.sprGnt   = 1'b1;
      end
      OwnCpuWr: begin
        bus.vramAddr   = fifo_head.addr;
        bus.vramWe     = 1'b1;
        bus.vramWrData = fifo_head.data;
      end
      OwnCpuRd: bus.vramAddr = rd_addr;
      default:  ;
    endcase
  end

  // Port cycle t -> data cycle t+1: remember who issued the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_owner         <= OwnNone;
      rd_pend            <= 1'b0;
      starve_cnt         <= '0;
      bus.cpuRdData      <= '0;
      bus.cpuRdDataValid <= 1'b0;
    end else begin
      data_owner         <= (owner == OwnCpuWr) ? OwnNone : owner;
      bus.cpuRdDataValid <= (data_owner == OwnCpuRd);
      if (data_owner == OwnCpuRd) bus.cpuRdData <= bus.vramOut;

      if (owner == OwnCpuRd)  rd_pend <= 1'b0;
      else if (rd_accept)     rd_pend <= 1'b1;

      if (!cpu_wait || owner == OwnCpuWr || owner == OwnCpuRd) starve_cnt <= '0;
      else if (owner == OwnSpr && starve_cnt != 4'hF)          starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) rd_addr <= bus.cpuRdAddr;
  end

  assign bus.sprDataValid = (data_owner == OwnSpr);
endmodule
